// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage with ID/EXE register, operand forwarding, ALU
// and a 32-step iterative multiply/divide unit that stalls the front end.
module exe_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_wreg,
    input  logic        id_m2reg,
    input  logic        id_wmem,
    input  logic [3:0]  id_aluc,
    input  logic        id_aluimm,
    input  logic        id_shift,
    input  logic [31:0] id_inA,
    input  logic [31:0] id_inB,
    input  logic [31:0] id_imm,
    input  logic [1:0]  id_fwdA,
    input  logic [1:0]  id_fwdB,
    input  logic [4:0]  id_destR,
    input  logic [3:0]  ID_ins_type,
    input  logic [3:0]  ID_ins_number,
    input  logic [31:0] mem_aluR,
    input  logic [31:0] wb_data,
    output logic        ex_wreg,
    output logic        ex_m2reg,
    output logic        ex_wmem,
    output logic [31:0] ex_aluR,
    output logic [31:0] ex_inB,
    output logic [4:0]  ex_destR,
    output logic [3:0]  EXE_ins_type,
    output logic [3:0]  EXE_ins_number,
    output logic        ex_busy
);
    localparam int CW = $clog2(MD_CYCLES);

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [3:0]  aluc;
        logic        aluimm;
        logic        shift;
        logic [31:0] in_a;
        logic [31:0] in_b;
        logic [31:0] imm;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic [4:0]  dest_r;
        logic [3:0]  ins_type;
        logic [3:0]  ins_number;
    } idex_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    idex_t          ex_q, ex_d;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    a_q, a_d, b_q, b_d, r_q, r_d;
    logic [31:0]    fwd_a, fwd_b, op_b, alu;
    logic [4:0]     sh;
    logic           is_md;
    logic [32:0]    trial, diff;

    always_comb begin
        fwd_a = ex_q.fwd_a == 2'd1 ? mem_aluR : ex_q.fwd_a == 2'd2 ? wb_data : ex_q.in_a;
        fwd_b = ex_q.fwd_b == 2'd1 ? mem_aluR : ex_q.fwd_b == 2'd2 ? wb_data : ex_q.in_b;
        op_b  = ex_q.aluimm ? ex_q.imm : fwd_b;
        sh    = ex_q.shift ? ex_q.imm[10:6] : fwd_a[4:0];
        is_md = ex_q.aluc == 4'd10 || ex_q.aluc == 4'd11 || ex_q.aluc == 4'd12;
        ex_busy = (state_q == IDLE && is_md) || state_q == RUN;
        ex_d  = ex_busy ? ex_q : {id_wreg, id_m2reg, id_wmem, id_aluc, id_aluimm, id_shift,
                                  id_inA, id_inB, id_imm, id_fwdA, id_fwdB, id_destR,
                                  ID_ins_type, ID_ins_number};
    end

    always_comb begin
        case (ex_q.aluc)
            4'd0:    alu = fwd_a + op_b;
            4'd1:    alu = fwd_a - op_b;
            4'd2:    alu = fwd_a & op_b;
            4'd3:    alu = fwd_a | op_b;
            4'd4:    alu = fwd_a ^ op_b;
            4'd5:    alu = op_b << sh;
            4'd6:    alu = op_b >> sh;
            4'd7:    alu = $signed(op_b) >>> sh;
            4'd8:    alu = {31'd0, $signed(fwd_a) < $signed(op_b)};
            4'd9:    alu = {op_b[15:0], 16'h0};
            4'd10:   alu = r_q;
            4'd11:   alu = a_q;
            4'd12:   alu = r_q;
            default: alu = 32'd0;
        endcase
    end

    // MULU: a=multiplicand, b=multiplier, r=accumulator.
    // DIVU/REMU: a=dividend shifting into quotient, b=divisor, r=remainder;
    // a zero divisor naturally yields all-ones quotient and remainder=dividend.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        trial   = {r_q, a_q[31]};
        diff    = trial - {1'b0, b_q};
        case (state_q)
            IDLE: if (is_md) begin
                state_d = RUN;
                cnt_d   = '0;
                a_d     = fwd_a;
                b_d     = fwd_b;
                r_d     = 32'd0;
            end
            RUN: begin
                if (ex_q.aluc == 4'd10) begin
                    r_d = b_q[0] ? r_q + a_q : r_q;
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end else begin
                    r_d = diff[32] ? trial[31:0] : diff[31:0];
                    a_d = {a_q[30:0], ~diff[32]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(MD_CYCLES - 1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
        end
    end

    assign ex_wreg        = ex_q.wreg & ~ex_busy;
    assign ex_wmem        = ex_q.wmem & ~ex_busy;
    assign ex_m2reg       = ex_q.m2reg;
    assign ex_aluR        = alu;
    assign ex_inB         = fwd_b;
    assign ex_destR       = ex_q.dest_r;
    assign EXE_ins_type   = ex_q.ins_type;
    assign EXE_ins_number = ex_q.ins_number;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vectors for exe_stage with hand-computed expectations.
module tb_exe_stage;
    logic        clk = 0;
    logic        rst_n;
    logic        id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift;
    logic [3:0]  id_aluc, ID_ins_type, ID_ins_number;
    logic [31:0] id_inA, id_inB, id_imm, mem_aluR, wb_data;
    logic [1:0]  id_fwdA, id_fwdB;
    logic [4:0]  id_destR;
    logic        ex_wreg, ex_m2reg, ex_wmem, ex_busy;
    logic [31:0] ex_aluR, ex_inB;
    logic [4:0]  ex_destR;
    logic [3:0]  EXE_ins_type, EXE_ins_number;
    int          n_vec = 0;
    int          n_err = 0;

    exe_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
        .id_aluc(id_aluc), .id_aluimm(id_aluimm), .id_shift(id_shift),
        .id_inA(id_inA), .id_inB(id_inB), .id_imm(id_imm),
        .id_fwdA(id_fwdA), .id_fwdB(id_fwdB), .id_destR(id_destR),
        .ID_ins_type(ID_ins_type), .ID_ins_number(ID_ins_number),
        .mem_aluR(mem_aluR), .wb_data(wb_data),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
        .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
        .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
        .ex_busy(ex_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic aluimm, input logic shift);
        id_aluc = op; id_inA = a; id_inB = b; id_imm = imm;
        id_aluimm = aluimm; id_shift = shift;
        id_wreg = 1; id_m2reg = 0; id_wmem = 0;
        id_fwdA = 0; id_fwdB = 0; id_destR = 5'd3;
        ID_ins_type = 4'h2; ID_ins_number = op;
    endtask

    task automatic apply;
        @(posedge clk); #1;
    endtask

    // Latches the op, queues an ADD 0x11+0x22 behind it, then times the stall.
    task automatic md_run(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic fwd);
        int n = 0;
        logic wr = 0;
        set_op(op, a, b, 0, 0, 0);
        if (fwd) begin id_fwdA = 1; mem_aluR = a; id_inA = 32'h0; end
        apply;
        set_op(4'd0, 32'h11, 32'h22, 0, 0, 0);
        id_destR = 5'd7;
        while (ex_busy && n < 100) begin
            n++;
            if (ex_wreg) wr = 1;
            apply;
            if (n == 1) begin mem_aluR = 32'hBADBAD; wb_data = 32'h5A5A5A; end
        end
        chk({tag, " busy cycles"}, n, 33);
        chk({tag, " wreg during busy"}, {31'd0, wr}, 0);
        chk({tag, " result"}, ex_aluR, exp);
        chk({tag, " wreg at done"}, {31'd0, ex_wreg}, 1);
        chk({tag, " dest at done"}, {27'd0, ex_destR}, 3);
        apply;
        chk({tag, " next instr"}, ex_aluR, 32'h33);
        chk({tag, " next dest"}, {27'd0, ex_destR}, 7);
        chk({tag, " next busy"}, {31'd0, ex_busy}, 0);
    endtask

    initial begin
        rst_n = 0; mem_aluR = 0; wb_data = 0;
        set_op(4'd0, 32'd3, 32'd4, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset aluR", ex_aluR, 0);
        chk("reset wreg", {31'd0, ex_wreg}, 0);
        chk("reset busy", {31'd0, ex_busy}, 0);
        chk("reset destR", {27'd0, ex_destR}, 0);
        chk("reset type", {28'd0, EXE_ins_type}, 0);
        @(negedge clk) rst_n = 1;

        set_op(4'd1, 32'd5, 32'd7, 0, 0, 0); apply;
        chk("SUB 5-7", ex_aluR, 32'hFFFFFFFE);
        set_op(4'd7, 32'd0, 32'h80000000, 32'd4 << 6, 0, 1); apply;
        chk("SRA", ex_aluR, 32'hF8000000);
        set_op(4'd8, 32'hFFFFFFFF, 32'd1, 0, 0, 0); apply;
        chk("SLT -1<1", ex_aluR, 32'h1);
        set_op(4'd9, 32'd0, 32'd0, 32'h1234, 1, 0); apply;
        chk("LUI", ex_aluR, 32'h12340000);

        set_op(4'd0, 32'd1, 32'd2, 0, 0, 0);
        id_fwdA = 1; id_fwdB = 2; mem_aluR = 100; wb_data = 23; apply;
        chk("fwd ADD", ex_aluR, 123);
        chk("fwd inB", ex_inB, 23);

        set_op(4'd0, 32'h40, 32'hDEADBEEF, 32'd8, 1, 0);
        id_wreg = 0; id_wmem = 1; ID_ins_type = 4'h5; ID_ins_number = 4'h9; apply;
        chk("store addr", ex_aluR, 32'h48);
        chk("store data", ex_inB, 32'hDEADBEEF);
        chk("store wmem", {31'd0, ex_wmem}, 1);
        chk("store type", {28'd0, EXE_ins_type}, 5);
        chk("store number", {28'd0, EXE_ins_number}, 9);

        md_run("MULU", 4'd10, 32'h10001, 32'h10001, 32'h00020001, 0);
        md_run("DIVU", 4'd11, 32'd100, 32'd7, 32'd14, 1);
        md_run("REMU", 4'd12, 32'd100, 32'd7, 32'd2, 0);
        md_run("DIVU0", 4'd11, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
        md_run("REMU0", 4'd12, 32'd5, 32'd0, 32'd5, 0);

        set_op(4'd11, 32'd100, 32'd7, 0, 0, 0); apply;
        repeat (5) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst busy", {31'd0, ex_busy}, 0);
        chk("midrst aluR", ex_aluR, 0);
        chk("midrst inB", ex_inB, 0);
        chk("midrst destR", {27'd0, ex_destR}, 0);
        chk("midrst number", {28'd0, EXE_ins_number}, 0);
        set_op(4'd0, 32'd3, 32'd4, 0, 0, 0);
        @(negedge clk) rst_n = 1;
        apply;
        chk("post-reset ADD", ex_aluR, 7);
        chk("post-reset busy", {31'd0, ex_busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly upstream of the memory stage.
- Contains the ID/EXE pipeline register, operand forwarding muxes and a single-cycle ALU.
- Contains an iterative 32-cycle multiply/divide unit that stalls the front end while it runs.
- Outputs map one-to-one onto the memory stage inputs (ex_wreg, ex_m2reg, ex_wmem, ex_aluR, ex_inB, ex_destR, EXE_ins_type, EXE_ins_number).

Parameters:
- MD_CYCLES, 32, iteration count of the multiply/divide unit; fixed at 32 for 32-bit operands.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_wreg, id_m2reg, id_wmem  input  1 each  decoded control bits
- id_aluc  input  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 LUI, 10 MULU (low word), 11 DIVU (quotient), 12 REMU; 13-15 give result 0
- id_aluimm  input  1  B operand = id_imm
- id_shift  input  1  shift amount = id_imm[10:6], otherwise A[4:0]
- id_inA, id_inB, id_imm  input  32 each  register operands and sign/zero-extended immediate
- id_fwdA, id_fwdB  input  2 each  forwarding select: 0 register, 1 mem_aluR, 2 wb_data, 3 register
- id_destR  input  5  destination register
- ID_ins_type, ID_ins_number  input  4 each  debug tags
- mem_aluR, wb_data  input  32 each  forwarding sources
- ex_wreg, ex_m2reg, ex_wmem  output  1 each
- ex_aluR  output  32  ALU / multiply-divide result
- ex_inB  output  32  forwarded B register value (store data)
- ex_destR  output  5
- EXE_ins_type, EXE_ins_number  output  4 each
- ex_busy  output  1  stall request to IF/ID

Behaviour:
- Reset:
  - Asynchronous on rst_n=0.
  - ID/EXE register cleared: all controls 0, data 0, destR 0, tags 0.
  - FSM goes to IDLE and the counter to 0.
  - All outputs read 0, including ex_busy=0.
  - Reset mid-operation aborts the operation with no residual state.
- ID/EXE register:
  - Loads all id_* on a rising clk when ex_busy=0; holds when ex_busy=1.
  - The upstream stage holds its outputs while ex_busy=1.
- Forwarding:
  - Applied to the latched operands every cycle (combinational select of mem_aluR / wb_data).
  - ex_inB is the forwarded B before the immediate mux.
- ALU ops (ops 0-9, 13-15):
  - Combinational from the latch; single cycle.
  - Shifts use the low 5 bits of the amount. SRA is arithmetic.
  - LUI = {B[15:0],16'h0}. SLT yields 32'h1 or 32'h0.
  - ADD/SUB wrap modulo 2^32, with no overflow trap.
- Multiply/divide (ops 10-12), FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: if the latched op is 10-12, ex_busy=1. Next edge loads the forwarded A/B into internal operand registers, counter=0, goes to RUN.
  - RUN: one shift-add (MULU) or restoring-subtract (DIVU/REMU) step per cycle; ex_busy=1. After step MD_CYCLES-1 goes to DONE.
  - DONE: ex_busy=0, ex_aluR = result. The next edge accepts the next instruction and FSM returns to IDLE.
  - Instruction occupies EXE for 34 cycles (1 IDLE + 32 RUN + 1 DONE).
  - Back-to-back multiply/divide ops restart from IDLE.
- Bubble gating: while ex_busy=1, ex_wreg=0 and ex_wmem=0. No register or memory write reaches MEM until DONE.
- Divide by zero:
  - Quotient = 32'hFFFFFFFF, remainder = dividend.
  - Still takes the full 34 cycles.
- MULU returns the low 32 bits of the 64-bit product.
- Operand capture: forwarding sources may change during RUN without affecting the result.

Test Plan:
- Reset: rst_n low mid-DIVU -> all outputs 0, ex_busy=0 immediately; after release the next ADD 3+4 gives ex_aluR=7 one cycle after capture.
- ALU: SUB 5-7 -> 32'hFFFFFFFE; SRA 32'h80000000 by 4 -> 32'hF8000000; SLT -1<1 -> 1; LUI imm 16'h1234 -> 32'h12340000.
- Forwarding: id_fwdA=1, mem_aluR=100, id_fwdB=2, wb_data=23, ADD -> ex_aluR=123, ex_inB=23.
- MULU 32'h10001 * 32'h10001 -> ex_busy high for exactly 33 cycles, ex_wreg=0 throughout, then ex_aluR=32'h00020001 with ex_wreg=1 for one cycle; following instruction held in ID until then.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 32'hFFFFFFFF; REMU 5/0 -> 5; each takes 34 cycles.
- Store passthrough: id_wmem=1, aluimm, A=0x40, imm=8, B=32'hDEADBEEF -> ex_aluR=0x48, ex_inB=32'hDEADBEEF, ex_wmem=1, tags propagated unchanged.
